// File: rtl/packet_transmitter.sv
// Source end of the point-to-point packet link: queues write requests in a FIFO,
// frames each as one parallel packet, and retransmits until acked or retries run out.
module packet_transmitter #(
  parameter int ID_WIDTH   = 2,
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 8,
  parameter int MAX_RETRY  = 3
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      wr_en,
  input  logic [ID_WIDTH-1:0]                       dest_id,
  input  logic [ADDR_WIDTH-1:0]                     tx_addr,
  input  logic [DATA_WIDTH-1:0]                     data_in,
  output logic                                      full,
  output logic                                      empty,
  output logic                                      overflow,
  output logic [ID_WIDTH+ADDR_WIDTH+DATA_WIDTH-1:0] tx_out,
  output logic                                      tx_valid,
  input  logic                                      ack_in,
  input  logic [ID_WIDTH-1:0]                       ack_id,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      err
);

  localparam int PKT_W = ID_WIDTH + ADDR_WIDTH + DATA_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam int RTY_W = $clog2(MAX_RETRY + 2);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK} state_t;

  state_t             state, state_next;
  logic [PKT_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [TMR_W-1:0]   timer, timer_next;
  logic [RTY_W-1:0]   retry_cnt, retry_next;
  logic               push, pop, load_head, ack_match;

  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign push     = wr_en && !full;
  assign overflow = wr_en && full;

  // NOTE: the storage array is deliberately left without reset; the pointers and
  // count are reset, so stale entries can never be read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {dest_id, tx_addr, data_in};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // The held packet lives in tx_out itself, so it only changes when a new head
  // is latched and otherwise holds between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      retry_cnt <= '0;
      tx_out    <= '0;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      retry_cnt <= retry_next;
      if (load_head) tx_out <= mem[rd_ptr];
    end
  end

  assign ack_match = ack_in && (ack_id == tx_out[PKT_W-1 -: ID_WIDTH]);
  assign tx_valid  = (state == SEND);
  assign busy      = (state != IDLE);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    timer_next = timer;
    retry_next = retry_cnt;
    load_head  = 1'b0;
    pop        = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          load_head  = 1'b1;
          retry_next = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        timer_next = '0;
        state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        // A matching ack beats a timeout in the same cycle.
        if (ack_match) begin
          pop        = 1'b1;
          done       = 1'b1;
          state_next = IDLE;
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
          if (retry_cnt < RTY_W'(MAX_RETRY)) begin
            retry_next = retry_cnt + 1'b1;
            state_next = SEND;
          end else begin
            pop        = 1'b1;
            err        = 1'b1;
            state_next = IDLE;
          end
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_packet_transmitter.sv
// Self-checking bench for packet_transmitter: directed scenarios followed by
// randomized bursts checked against a queue-based transaction model.
module tb_packet_transmitter;

  localparam int IW = 2;
  localparam int AW = 2;
  localparam int DW = 2;
  localparam int FD = 4;
  localparam int TO = 8;
  localparam int MR = 3;
  localparam int PW = IW + AW + DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [IW-1:0] dest_id = '0;
  logic [AW-1:0] tx_addr = '0;
  logic [DW-1:0] data_in = '0;
  logic          ack_in = 1'b0;
  logic [IW-1:0] ack_id = '0;
  logic          full, empty, overflow, tx_valid, busy, done, err;
  logic [PW-1:0] tx_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [PW-1:0] q[$];

  packet_transmitter #(
    .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .FIFO_DEPTH(FD), .TIMEOUT(TO), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .dest_id(dest_id), .tx_addr(tx_addr),
    .data_in(data_in), .full(full), .empty(empty), .overflow(overflow),
    .tx_out(tx_out), .tx_valid(tx_valid), .ack_in(ack_in), .ack_id(ack_id),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_pkt(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    wr_en  = 1'b0;
    ack_in = 1'b0;
    cyc++;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic write(input logic [PW-1:0] p);
    wr_en = 1'b1;
    {dest_id, tx_addr, data_in} = p;
  endtask

  task automatic ack(input logic [IW-1:0] id);
    ack_in = 1'b1;
    ack_id = id;
  endtask

  task automatic wait_tx(input int limit, output int waited);
    waited = 0;
    while (waited < limit) begin
      next_cycle();
      sample();
      waited++;
      if (tx_valid) break;
    end
    check("wait_tx_seen", tx_valid, 1'b1);
  endtask

  initial begin
    int            waited, n, attempts, elapsed, ack_at, t_send;
    bit            never, retired, sent_pending, last;
    logic [PW-1:0] p, cur;
    logic [IW-1:0] cur_id;
    logic [PW-1:0] p4 [5];

    // Reset values
    #1 rst = 1'b1;
    #1;
    check("rst_full", full, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_overflow", overflow, 1'b0);
    check_pkt("rst_tx_out", tx_out, '0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic send and immediate ack
    next_cycle(); write(6'b010011); sample();
    check("t1_w_txv", tx_valid, 1'b0);
    check("t1_w_empty", empty, 1'b1);
    next_cycle(); sample();
    check("t1_idle_txv", tx_valid, 1'b0);
    check("t1_idle_empty", empty, 1'b0);
    next_cycle(); sample();
    check("t1_send_txv", tx_valid, 1'b1);
    check_pkt("t1_send_pkt", tx_out, 6'b010011);
    check("t1_send_busy", busy, 1'b1);
    next_cycle(); ack(2'b01); sample();
    check("t1_done", done, 1'b1);
    check("t1_ack_txv", tx_valid, 1'b0);
    next_cycle(); sample();
    check("t1_after_busy", busy, 1'b0);
    check("t1_after_empty", empty, 1'b1);
    check("t1_after_done", done, 1'b0);

    // Wrong-id acks are ignored; retransmit after timeout
    next_cycle(); write(6'b010011); sample();
    next_cycle(); sample();
    next_cycle(); sample();
    check("t2_send0", tx_valid, 1'b1);
    for (int w = 1; w <= TO; w++) begin
      next_cycle(); ack(2'b10); sample();
      check("t2_wait_done", done, 1'b0);
      check("t2_wait_txv", tx_valid, 1'b0);
    end
    next_cycle(); sample();
    check("t2_resend", tx_valid, 1'b1);
    check_pkt("t2_resend_pkt", tx_out, 6'b010011);
    next_cycle(); ack(2'b01); sample();
    check("t2_done", done, 1'b1);
    check("t2_ack_txv", tx_valid, 1'b0);
    next_cycle(); sample();
    check("t2_after_busy", busy, 1'b0);
    check("t2_after_txv", tx_valid, 1'b0);

    // Never acked: 4 attempts spaced 9 cycles, then err
    next_cycle(); write(6'b100101); sample();
    for (int k = 1; k <= 38; k++) begin
      next_cycle(); sample();
      check("t3_txv", tx_valid, k >= 2 && k <= 29 && (k - 2) % 9 == 0);
      check("t3_err", err, k == 37);
      check("t3_done", done, 1'b0);
      check("t3_empty", empty, k >= 38);
    end

    // Back-to-back writes: full after 4, overflow on 5th, in-order delivery
    for (int i = 0; i < 5; i++) p4[i] = PW'($urandom);
    for (int i = 0; i < 5; i++) begin
      next_cycle(); write(p4[i]); sample();
      check("t4_full", full, i == 4);
      check("t4_overflow", overflow, i == 4);
      if (i == 2) begin
        check("t4_first_txv", tx_valid, 1'b1);
        check_pkt("t4_first_pkt", tx_out, p4[0]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      wait_tx(20, waited);
      check_pkt("t4_order", tx_out, p4[i]);
      cur = p4[i];
      next_cycle(); ack(cur[PW-1 -: IW]); sample();
      check("t4_done", done, 1'b1);
    end
    for (int k = 0; k < 12; k++) begin
      next_cycle(); sample();
      check("t4_no_fifth", tx_valid, 1'b0);
      check("t4_empty", empty, 1'b1);
    end

    // Ack in the timeout cycle wins
    next_cycle(); write(6'b111010); sample();
    next_cycle(); sample();
    next_cycle(); sample();
    check("t5_send", tx_valid, 1'b1);
    for (int w = 1; w < TO; w++) begin
      next_cycle(); sample();
      check("t5_wait_done", done, 1'b0);
      check("t5_wait_txv", tx_valid, 1'b0);
    end
    next_cycle(); ack(2'b11); sample();
    check("t5_done", done, 1'b1);
    check("t5_err", err, 1'b0);
    check("t5_txv", tx_valid, 1'b0);
    for (int k = 0; k < 3; k++) begin
      next_cycle(); sample();
      check("t5_no_resend", tx_valid, 1'b0);
      check("t5_idle", busy, 1'b0);
      check("t5_empty", empty, 1'b1);
    end

    // Reset during WAIT_ACK with 3 entries queued
    for (int i = 0; i < 3; i++) begin
      next_cycle(); write(PW'($urandom)); sample();
    end
    for (int k = 0; k < 3; k++) begin
      next_cycle(); sample();
    end
    check("t6_pre_busy", busy, 1'b1);
    next_cycle();
    rst = 1'b1;
    #1;
    check("t6_full", full, 1'b0);
    check("t6_empty", empty, 1'b1);
    check("t6_overflow", overflow, 1'b0);
    check_pkt("t6_tx_out", tx_out, '0);
    check("t6_txv", tx_valid, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_done", done, 1'b0);
    check("t6_err", err, 1'b0);
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 25; k++) begin
      next_cycle(); sample();
      check("t6_quiet_txv", tx_valid, 1'b0);
      check("t6_quiet_done", done, 1'b0);
      check("t6_quiet_err", err, 1'b0);
      check("t6_quiet_empty", empty, 1'b1);
    end
    next_cycle(); write(6'b001100); sample();
    next_cycle(); sample();
    next_cycle(); sample();
    check("t6_recover_txv", tx_valid, 1'b1);
    check_pkt("t6_recover_pkt", tx_out, 6'b001100);
    next_cycle(); ack(2'b00); sample();
    check("t6_recover_done", done, 1'b1);
    next_cycle(); sample();

    // Randomized bursts against the transaction model
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(1, 6);
      sent_pending = 1'b0;
      t_send = 0;
      for (int i = 0; i < n; i++) begin
        p = PW'($urandom);
        next_cycle(); write(p); sample();
        check("rnd_full", full, q.size() == FD);
        check("rnd_overflow", overflow, q.size() == FD);
        check("rnd_empty", empty, q.size() == 0);
        check("rnd_burst_txv", tx_valid, i == 2);
        if (q.size() < FD) q.push_back(p);
        if (i == 2) begin
          check_pkt("rnd_burst_pkt", tx_out, q[0]);
          sent_pending = 1'b1;
          t_send = cyc;
        end
      end
      while (q.size() > 0) begin
        never    = ($urandom_range(0, 3) == 0);
        attempts = 0;
        retired  = 1'b0;
        cur      = q[0];
        cur_id   = cur[PW-1 -: IW];
        while (!retired) begin
          if (!sent_pending) begin
            wait_tx(20, waited);
            if (!tx_valid) begin
              q.delete();
              break;
            end
            t_send = cyc;
          end
          sent_pending = 1'b0;
          check_pkt("rnd_pkt", tx_out, cur);
          attempts++;
          elapsed = cyc - t_send;
          if (never || $urandom_range(0, 2) == 0) ack_at = 0;
          else ack_at = $urandom_range(elapsed + 1, TO);
          for (int w = elapsed + 1; w <= TO; w++) begin
            next_cycle();
            if (w == ack_at) ack(cur_id);
            else if ($urandom_range(0, 2) == 0) ack(cur_id ^ IW'($urandom_range(1, 3)));
            sample();
            last = (w == TO) && (attempts == MR + 1);
            check("rnd_done", done, w == ack_at);
            check("rnd_err", err, last && w != ack_at);
            check("rnd_wait_txv", tx_valid, 1'b0);
            if (w == ack_at || last) begin
              void'(q.pop_front());
              retired = 1'b1;
              break;
            end
          end
          if (!retired) begin
            next_cycle(); sample();
            check("rnd_resend", tx_valid, 1'b1);
            t_send = cyc;
            sent_pending = 1'b1;
          end
        end
        if (q.size() > 0) begin
          wait_tx(20, waited);
          check("rnd_gap", waited == 2, 1'b1);
          t_send = cyc;
          sent_pending = 1'b1;
        end
      end
      next_cycle(); sample();
      check("rnd_idle_busy", busy, 1'b0);
      check("rnd_idle_empty", empty, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/packet_transmitter.md
Name: packet_transmitter

Overview:
- Source end of the point-to-point packet link; the peer receiver consumes its packets.
- Accepts write requests (destination id, register address, data) into a small FIFO and frames each as one parallel packet on tx_out.
- Holds each packet until the addressed node acknowledges it, retransmits on timeout, and drops it with an error pulse once all retries are used.
- Sits between the core's store path and the photonic link driver.

Parameters:
- ID_WIDTH, 2, width of the node id field.
- ADDR_WIDTH, 2, width of the destination register address field.
- DATA_WIDTH, 2, width of the payload field.
- FIFO_DEPTH, 4, number of queued requests; power of 2, at least 2.
- TIMEOUT, 8, cycles spent in WAIT_ACK before a retransmit; at least 2.
- MAX_RETRY, 3, retransmits after the first send; total attempts = MAX_RETRY+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  enqueue request this cycle.
- dest_id  in  ID_WIDTH  destination node id.
- tx_addr  in  ADDR_WIDTH  destination register address.
- data_in  in  DATA_WIDTH  payload.
- full  out  1  FIFO full.
- empty  out  1  FIFO empty.
- overflow  out  1  one-cycle pulse: wr_en was high while full, request dropped.
- tx_out  out  ID_WIDTH+ADDR_WIDTH+DATA_WIDTH  packet {id, addr, data}, id in the MSBs.
- tx_valid  out  1  tx_out valid; one-cycle pulse per attempt.
- ack_in  in  1  acknowledge strobe from the link.
- ack_id  in  ID_WIDTH  id of the acknowledging node.
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle pulse: head packet acknowledged and retired.
- err  out  1  one-cycle pulse: head packet dropped after retries exhausted.

Behaviour:
- Reset: all outputs 0 except empty=1. FIFO pointers and count clear; FSM goes to IDLE; timer and retry counter clear. In-flight packets and queued requests are discarded.
- FIFO:
  - Registered count. full = (count==FIFO_DEPTH); empty = (count==0).
  - wr_en is accepted only when full=0 in that cycle. If wr_en and a pop coincide while full, the write is still rejected and overflow pulses.
  - A simultaneous push and pop while not full leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states IDLE, SEND, WAIT_ACK:
  - IDLE: if !empty, latch the FIFO head into the hold register, clear retry_cnt, go to SEND.
  - SEND: tx_valid=1 and tx_out=hold for exactly this cycle. Clear the timer and go to WAIT_ACK. ack_in is ignored in SEND.
  - WAIT_ACK, matching ack (ack_in=1 and ack_id equal to the held id): pop the FIFO, pulse done, go to IDLE.
  - WAIT_ACK, otherwise: increment the timer. When timer==TIMEOUT-1 and there is no matching ack:
    - if retry_cnt<MAX_RETRY: increment retry_cnt, go to SEND;
    - else: pop the FIFO, pulse err, go to IDLE.
  - An ack with a non-matching id is ignored and does not reset the timer.
  - An ack arriving in the same cycle as the timeout wins: done, no retry.
- tx_out holds its last value between pulses (0 after reset).
- Latency: a write into an empty, idle block produces tx_valid in the 2nd cycle after the write. Minimum per-packet occupancy is 3 cycles (IDLE, SEND, ack in the first WAIT_ACK cycle).
- busy=1 in SEND and WAIT_ACK.
- Reset asserted mid-WAIT_ACK: outputs clear asynchronously. No done or err pulse is generated for the aborted packet.

Test Plan:
- Reset, write id=01, addr=00, data=11 -> tx_valid pulse 2 cycles later with tx_out=6'b010011. ack_in=1, ack_id=01 next cycle -> done pulse; busy=0 and empty=1 the following cycle.
- Send to id=01, ack only with ack_id=10 -> no done. Retransmit of 6'b010011 (tx_valid) 8 cycles after the first WAIT_ACK cycle. A matching ack then -> done, exactly 2 tx_valid pulses total.
- Send to id=10, never ack -> 4 tx_valid pulses spaced 9 cycles apart, then an err pulse; FIFO count drops by 1.
- 5 back-to-back writes with no ack -> full=1 after the 4th, overflow pulse on the 5th. Packets later emerge in write order; the 5th never appears.
- Matching ack asserted in the timeout cycle (8th WAIT_ACK cycle) -> done, no retransmit.
- Assert rst during WAIT_ACK with 3 entries queued -> all outputs 0 and empty=1 immediately. No tx_valid, done or err until new writes arrive.
